// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned XLEN        = 32;
  // Latency counter is sized for the largest supported MEM_LAT.
  localparam int unsigned ARB_LAT_MAX = 15;
  localparam int unsigned ARB_LAT_W   = $clog2(ARB_LAT_MAX + 1);

  typedef enum logic {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Starvation guard: counts data grants taken while fetch waits and forces a
// fetch grant once the limit is reached.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic grant_if,
  input  logic grant_d,
  input  logic if_req,
  input  logic if_elig,
  output logic force_if
);

  localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CntW-1:0] starve_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
    end else if (grant_if) begin
      starve_cnt_q <= '0;
    end else if (grant_d) begin
      if (if_elig) begin
        if (starve_cnt_q != CntW'(STARVE_MAX)) begin
          starve_cnt_q <= starve_cnt_q + CntW'(1);
        end
      end else if (!if_req) begin
        starve_cnt_q <= '0;
      end
    end
  end

  assign force_if = (starve_cnt_q == CntW'(STARVE_MAX));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch (read-only) and data (read/write) requests onto one
// fixed-latency single-ported memory, returning data with a one-cycle ready.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  output logic            if_stall,
  input  logic            d_req,
  input  logic            d_wr,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ready,
  output logic            d_stall,
  output logic            mem_en,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  arb_state_t           state_q;
  arb_owner_t           owner_q;
  logic [XLEN-1:0]      addr_q;
  logic [XLEN-1:0]      wdata_q;
  logic                 wr_q;
  logic [ARB_LAT_W-1:0] lat_cnt_q;
  logic                 discard_q;
  logic                 mem_en_q;
  logic                 mem_wr_q;
  logic [XLEN-1:0]      if_rdata_q;
  logic [XLEN-1:0]      d_rdata_q;
  logic                 if_ready_q;
  logic                 d_ready_q;

  logic if_elig;
  logic d_elig;
  logic force_if;
  logic grant_if;
  logic grant_d;

  // A requester in its own ready cycle is not eligible: its req is still high
  // only because it drops it on the edge that ends that cycle.
  assign if_elig  = if_req & ~if_ready_q;
  assign d_elig   = d_req & ~d_ready_q;
  assign grant_if = (state_q == ARB_IDLE) & if_elig & (~d_elig | force_if);
  assign grant_d  = (state_q == ARB_IDLE) & d_elig & ~grant_if;

  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .grant_if(grant_if),
    .grant_d (grant_d),
    .if_req  (if_req),
    .if_elig (if_elig),
    .force_if(force_if)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      lat_cnt_q  <= '0;
      discard_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_if || grant_d) begin
            state_q   <= ARB_WAIT;
            owner_q   <= grant_if ? OWN_IF : OWN_D;
            addr_q    <= grant_if ? if_addr : d_addr;
            wdata_q   <= grant_d ? d_wdata : '0;
            wr_q      <= grant_d & d_wr;
            mem_en_q  <= 1'b1;
            mem_wr_q  <= grant_d & d_wr;
            lat_cnt_q <= ARB_LAT_W'(MEM_LAT);
            discard_q <= 1'b0;
          end
        end
        ARB_WAIT: begin
          if (owner_q == OWN_IF && if_flush) begin
            discard_q <= 1'b1;
          end
          if (lat_cnt_q == '0) begin
            state_q   <= ARB_IDLE;
            discard_q <= 1'b0;
            if (owner_q == OWN_IF) begin
              // A flush in the final cycle still kills the result.
              if (!(discard_q || if_flush)) begin
                if_rdata_q <= mem_rdata;
                if_ready_q <= 1'b1;
              end
            end else begin
              d_ready_q <= 1'b1;
              if (!wr_q) begin
                d_rdata_q <= mem_rdata;
              end
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - ARB_LAT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign d_stall   = d_req & ~d_ready_q;
  assign busy      = (state_q == ARB_WAIT);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and randomized bench for unified_mem_arbiter against a
// transaction-level model keyed on grant cycle numbers.
module tb_unified_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_stall;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  unified_mem_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .if_stall (if_stall),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .d_stall  (d_stall),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one access at most in flight, described by its grant cycle.
  logic [31:0] mem [logic [31:0]];
  bit          m_busy, m_own_d, m_wr, m_disc;
  int          m_gcyc, m_starve;
  logic [31:0] m_addr, m_wdata;
  int          if_rdy_cyc, d_rdy_cyc;
  logic [31:0] e_if_rdata, e_d_rdata;
  int          cyc, tcyc;
  bit          last_if_rdy, last_d_rdy;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_disc = 0; m_starve = 0;
    if_rdy_cyc = -1000; d_rdy_cyc = -1000;
    e_if_rdata = '0; e_d_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_if_ready"}, {31'd0, if_ready}, 0);
    chk({tag, "_if_stall"}, {31'd0, if_stall}, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_d_ready"}, {31'd0, d_ready}, 0);
    chk({tag, "_d_stall"}, {31'd0, d_stall}, 0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 0);
    chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // One clock cycle: check outputs at the falling edge, answer for the
  // memory, then advance the model across the rising edge.
  task automatic tick();
    bit e_if_rdy, e_d_rdy, e_mem_en, if_e, d_e, done;
    @(negedge clk);
    e_if_rdy = (if_rdy_cyc == cyc);
    e_d_rdy  = (d_rdy_cyc == cyc);
    e_mem_en = m_busy && (cyc == m_gcyc + 1);
    done     = m_busy && (cyc == m_gcyc + 1 + MEM_LAT);
    chk("if_ready", {31'd0, if_ready}, {31'd0, e_if_rdy});
    chk("d_ready", {31'd0, d_ready}, {31'd0, e_d_rdy});
    chk("if_stall", {31'd0, if_stall}, {31'd0, if_req && !e_if_rdy});
    chk("d_stall", {31'd0, d_stall}, {31'd0, d_req && !e_d_rdy});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_mem_en});
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_mem_en && m_wr});
    if (e_mem_en) chk("mem_addr", mem_addr, m_addr);
    if (e_mem_en && m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);

    mem_rdata = (done && !m_wr) ? mem_rd(m_addr) : $urandom;
    if (m_busy && !m_own_d && if_flush) m_disc = 1;

    if (done) begin
      m_busy = 0;
      if (!m_own_d) begin
        if (!m_disc) begin
          e_if_rdata = mem_rd(m_addr);
          if_rdy_cyc = cyc + 1;
        end
      end else begin
        d_rdy_cyc = cyc + 1;
        if (!m_wr) e_d_rdata = mem_rd(m_addr);
      end
    end else if (!m_busy) begin
      if_e = if_req && !e_if_rdy;
      d_e  = d_req && !e_d_rdy;
      if (if_e && (!d_e || m_starve >= STARVE_MAX)) begin
        m_busy = 1; m_own_d = 0; m_gcyc = cyc; m_addr = if_addr; m_wr = 0;
        m_disc = 0; m_starve = 0;
      end else if (d_e) begin
        m_busy = 1; m_own_d = 1; m_gcyc = cyc; m_addr = d_addr; m_wr = d_wr;
        m_wdata = d_wdata; m_disc = 0;
        if (d_wr) mem[d_addr] = d_wdata;
        if (if_e) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else if (!if_req) m_starve = 0;
      end
    end
    last_if_rdy = e_if_rdy;
    last_d_rdy  = e_d_rdy;
    tcyc = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit want_if, input string tag, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (want_if ? last_if_rdy : last_d_rdy) begin
        at = tcyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no-ready expected=ready-within-40", tag);
    end
  endtask

  int t0, at, max_wait, since_if, nfetch;
  logic [31:0] saved;

  initial begin
    rst = 0; if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    model_reset();
    cyc = 0;
    mem[32'h10]  = 32'h0050_0093;
    mem[32'h300] = 32'h1111_1111;
    mem[32'h304] = 32'h2222_2222;
    mem[32'h500] = 32'h5555_0500;
    mem[32'h504] = 32'hCAFE_F00D;
    #3;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    repeat (2) tick();

    // 1: single fetch
    t0 = cyc; if_req = 1; if_addr = 32'h10;
    wait_rdy(1, "t1", at);
    chk("t1_latency", at - t0, 4);
    chk("t1_if_rdata", if_rdata, 32'h0050_0093);
    if_req = 0;
    repeat (2) tick();

    // 2: simultaneous store and fetch; data first
    saved = e_d_rdata;
    t0 = cyc;
    d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h14;
    wait_rdy(0, "t2_d", at);
    chk("t2_d_latency", at - t0, 4);
    d_req = 0; d_wr = 0;
    wait_rdy(1, "t2_if", at);
    chk("t2_if_latency", at - t0, 8);
    chk("t2_d_rdata_kept", d_rdata, saved);
    if_req = 0;
    repeat (2) tick();

    // 3: continuous loads with fetch held; fetch must keep making progress
    d_req = 1; d_addr = 32'h200; if_req = 1; if_addr = 32'h40;
    max_wait = 0; since_if = 0; nfetch = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (last_d_rdy) begin
        d_addr += 4; since_if++;
        if (since_if > max_wait) max_wait = since_if;
      end
      if (last_if_rdy) begin
        if_addr += 4; since_if = 0; nfetch++;
      end
    end
    chk("t3_fetch_wait_le3", {31'd0, max_wait <= 3}, 1);
    chk("t3_fetch_progress", {31'd0, nfetch >= 5}, 1);
    for (int i = 0; i < 40 && (d_req || if_req); i++) begin
      tick();
      if (last_d_rdy) d_req = 0;
      if (last_if_rdy) if_req = 0;
    end
    repeat (2) tick();

    // 4: flushed fetch yields no ready; a new fetch follows
    saved = e_if_rdata;
    t0 = cyc; if_req = 1; if_addr = 32'h80;
    tick(); tick();
    if_flush = 1; if_addr = 32'h84;
    tick();
    if_flush = 0;
    tick();
    chk("t4_idle", {31'd0, busy}, 0);
    chk("t4_if_rdata_kept", if_rdata, saved);
    wait_rdy(1, "t4", at);
    chk("t4_latency", at - t0, 8);
    chk("t4_if_rdata", if_rdata, mem_rd(32'h84));
    if_req = 0;
    repeat (2) tick();

    // 5: reset during an in-flight load
    t0 = cyc; d_req = 1; d_wr = 0; d_addr = 32'h500;
    tick(); tick();
    d_req = 0; rst = 0;
    #1;
    chk_all_zero("t5_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1; cyc++;
    repeat (3) tick();
    t0 = cyc; d_req = 1; d_addr = 32'h504;
    wait_rdy(0, "t5", at);
    chk("t5_latency", at - t0, 4);
    chk("t5_d_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 0;
    repeat (2) tick();

    // 6: back-to-back loads
    t0 = cyc; d_req = 1; d_addr = 32'h300;
    wait_rdy(0, "t6_a", at);
    chk("t6_a_latency", at - t0, 4);
    chk("t6_a_data", d_rdata, 32'h1111_1111);
    t0 = cyc; d_addr = 32'h304;
    wait_rdy(0, "t6_b", at);
    chk("t6_b_latency", at - t0, 4);
    chk("t6_b_data", d_rdata, 32'h2222_2222);
    d_req = 0;
    repeat (2) tick();

    // Randomized traffic with flushes
    for (int i = 0; i < 800; i++) begin
      tick();
      if (last_if_rdy || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = {$urandom_range(0, 255), 2'b00};
      end
      if (last_d_rdy || !d_req) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_wr = $urandom_range(0, 1);
        d_addr = 32'h200 + {$urandom_range(0, 15), 2'b00};
        d_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 7) == 0);
      if (if_flush && m_busy && !m_own_d) if_addr = {$urandom_range(0, 255), 2'b00};
    end
    if_flush = 0;
    for (int i = 0; i < 60 && (d_req || if_req); i++) begin
      tick();
      if (last_d_rdy) d_req = 0;
      if (last_if_rdy) if_req = 0;
      // a discarded fetch never readies, so release it once the bus is idle
      if (if_req && !m_busy && d_req == 0 && i > 30) if_req = 0;
    end
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
